// File: rtl/tcu_core_req_regs.sv
// rtl/tcu_core_req_regs.sv - CORE_REQ / CORE_REQ_INT register slave with round-robin priv/core port arbitration
module tcu_core_req_regs #(
    parameter int                           TCU_REG_DATA_SIZE    = 64,
    parameter int                           TCU_REG_ADDR_SIZE    = 32,
    parameter int                           TCU_REG_BSEL_SIZE    = TCU_REG_DATA_SIZE / 8,
    parameter logic [TCU_REG_ADDR_SIZE-1:0] REGADDR_CORE_REQ     = 32'h0000_3000,
    parameter logic [TCU_REG_ADDR_SIZE-1:0] REGADDR_CORE_REQ_INT = 32'h0000_3108
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,

    input  logic                         priv_reg_en_i,
    input  logic [TCU_REG_BSEL_SIZE-1:0] priv_reg_wben_i,
    input  logic [TCU_REG_ADDR_SIZE-1:0] priv_reg_addr_i,
    input  logic [TCU_REG_DATA_SIZE-1:0] priv_reg_wdata_i,
    output logic [TCU_REG_DATA_SIZE-1:0] priv_reg_rdata_o,
    output logic                         priv_reg_stall_o,

    input  logic                         core_reg_en_i,
    input  logic [TCU_REG_BSEL_SIZE-1:0] core_reg_wben_i,
    input  logic [TCU_REG_ADDR_SIZE-1:0] core_reg_addr_i,
    input  logic [TCU_REG_DATA_SIZE-1:0] core_reg_wdata_i,
    output logic [TCU_REG_DATA_SIZE-1:0] core_reg_rdata_o,
    output logic                         core_reg_stall_o,

    output logic                         core_irq_o
);

    logic [1:0]                   rst_sync_q;
    logic                         rst_n;
    logic                         rr_q;
    logic [TCU_REG_DATA_SIZE-1:0] req_q;
    logic [TCU_REG_DATA_SIZE-1:0] int_q;
    logic                         irq_q;

    logic                         grant_priv;
    logic                         grant_core;
    logic                         acc_en;
    logic [TCU_REG_BSEL_SIZE-1:0] acc_wben;
    logic [TCU_REG_ADDR_SIZE-1:0] acc_addr;
    logic [TCU_REG_DATA_SIZE-1:0] acc_wdata;
    logic                         acc_read;
    logic                         hit_req;
    logic                         hit_int;
    logic [TCU_REG_DATA_SIZE-1:0] rd_val;

    // Assert asynchronously, release two edges after reset_n_i rises.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // rr_q=0 favours priv on contention; a lone requester always wins.
    assign grant_priv = rst_n & priv_reg_en_i & (~core_reg_en_i | ~rr_q);
    assign grant_core = rst_n & core_reg_en_i & (~priv_reg_en_i | rr_q);

    assign priv_reg_stall_o = rst_n & priv_reg_en_i & ~grant_priv;
    assign core_reg_stall_o = rst_n & core_reg_en_i & ~grant_core;

    always_comb begin
        acc_en    = grant_priv | grant_core;
        acc_wben  = priv_reg_wben_i;
        acc_addr  = priv_reg_addr_i;
        acc_wdata = priv_reg_wdata_i;
        if (grant_core) begin
            acc_wben  = core_reg_wben_i;
            acc_addr  = core_reg_addr_i;
            acc_wdata = core_reg_wdata_i;
        end
    end

    assign acc_read = acc_en & (acc_wben == '0);
    assign hit_req  = (acc_addr == REGADDR_CORE_REQ);
    assign hit_int  = (acc_addr == REGADDR_CORE_REQ_INT);

    always_comb begin
        rd_val = '0;
        if (hit_req) begin
            rd_val = req_q;
        end else if (hit_int) begin
            rd_val = int_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
            int_q <= '0;
        end else if (acc_en && !acc_read) begin
            for (int b = 0; b < TCU_REG_BSEL_SIZE; b++) begin
                if (acc_wben[b] && hit_req) begin
                    req_q[b*8 +: 8] <= acc_wdata[b*8 +: 8];
                end
                if (acc_wben[b] && hit_int) begin
                    int_q[b*8 +: 8] <= acc_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            priv_reg_rdata_o <= '0;
            core_reg_rdata_o <= '0;
            rr_q             <= 1'b0;
            irq_q            <= 1'b0;
        end else begin
            if (grant_priv && acc_read) begin
                priv_reg_rdata_o <= rd_val;
            end
            if (grant_core && acc_read) begin
                core_reg_rdata_o <= rd_val;
            end
            if (grant_priv) begin
                rr_q <= 1'b1;
            end else if (grant_core) begin
                rr_q <= 1'b0;
            end
            irq_q <= int_q[0];
        end
    end

    assign core_irq_o = irq_q;

endmodule

// File: tb/tb_tcu_core_req_regs.sv
// tb/tb_tcu_core_req_regs.sv - scoreboard bench for tcu_core_req_regs
module tb_tcu_core_req_regs;

    localparam logic [31:0] A_REQ   = 32'h0000_3000;
    localparam logic [31:0] A_INT   = 32'h0000_3108;
    localparam logic [31:0] A_UNMAP = 32'h0000_3100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        priv_en = 1'b0;
    logic [7:0]  priv_wben = '0;
    logic [31:0] priv_addr = '0;
    logic [63:0] priv_wdata = '0;
    logic [63:0] priv_rdata;
    logic        priv_stall;
    logic        core_en = 1'b0;
    logic [7:0]  core_wben = '0;
    logic [31:0] core_addr = '0;
    logic [63:0] core_wdata = '0;
    logic [63:0] core_rdata;
    logic        core_stall;
    logic        core_irq;

    int tests = 0;
    int fails = 0;

    logic [63:0] req_m;
    logic [63:0] int_m;
    logic [63:0] q_priv[$];
    logic [63:0] q_core[$];

    always #5 clk = ~clk;

    tcu_core_req_regs dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .priv_reg_en_i    (priv_en),
        .priv_reg_wben_i  (priv_wben),
        .priv_reg_addr_i  (priv_addr),
        .priv_reg_wdata_i (priv_wdata),
        .priv_reg_rdata_o (priv_rdata),
        .priv_reg_stall_o (priv_stall),
        .core_reg_en_i    (core_en),
        .core_reg_wben_i  (core_wben),
        .core_reg_addr_i  (core_addr),
        .core_reg_wdata_i (core_wdata),
        .core_reg_rdata_o (core_rdata),
        .core_reg_stall_o (core_stall),
        .core_irq_o       (core_irq)
    );

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [7:0] wben,
                                          input logic [63:0] wdata);
        logic [63:0] r = old;
        for (int b = 0; b < 8; b++) if (wben[b]) r[b*8 +: 8] = wdata[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] model_read(input logic [31:0] addr);
        if (addr == A_REQ) return req_m;
        if (addr == A_INT) return int_m;
        return 64'h0;
    endfunction

    // Model bookkeeping for one accepted access.
    task automatic model_accept(input bit core, input logic [7:0] wben, input logic [31:0] addr,
                                input logic [63:0] wdata);
        if (wben == 8'h00) begin
            if (core) q_core.push_back(model_read(addr));
            else      q_priv.push_back(model_read(addr));
        end else if (addr == A_REQ) begin
            req_m = merge(req_m, wben, wdata);
        end else if (addr == A_INT) begin
            int_m = merge(int_m, wben, wdata);
        end
    endtask

    // Enters and leaves at posedge+1; stall is sampled on the negedge before each edge.
    task automatic access(input bit core, input logic [7:0] wben, input logic [31:0] addr,
                          input logic [63:0] wdata);
        bit acc = 1'b0;
        if (core) begin
            core_en = 1'b1; core_wben = wben; core_addr = addr; core_wdata = wdata;
        end else begin
            priv_en = 1'b1; priv_wben = wben; priv_addr = addr; priv_wdata = wdata;
        end
        for (int n = 0; n < 4 && !acc; n++) begin
            @(negedge clk);
            acc = core ? !core_stall : !priv_stall;
            if (acc) model_accept(core, wben, addr, wdata);
            @(posedge clk); #1;
        end
        if (core) core_en = 1'b0; else priv_en = 1'b0;
        if (!acc) begin
            tests++; fails++;
            $display("FAIL accept_timeout port=%0d addr=%h: not accepted, required within 4 cycles", core, addr);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        priv_en = 1'b0;
        core_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req_m = '0;
        int_m = '0;
        q_priv.delete();
        q_core.delete();
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [63:0] exp;
        do_reset();
        tests++;
        if (core_irq !== 1'b0 || priv_stall !== 1'b0 || core_stall !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: irq=%b pstall=%b cstall=%b, required 0 0 0", core_irq, priv_stall, core_stall);
        end
        tests++;
        if (priv_rdata !== 64'h0 || core_rdata !== 64'h0) begin
            fails++;
            $display("FAIL reset_rdata: priv=%h core=%h, required 0", priv_rdata, core_rdata);
        end
        access(1'b0, 8'h00, A_INT, 64'h0);
        exp = (q_priv.size() != 0) ? q_priv.pop_front() : 64'hx;
        tests++;
        if (priv_rdata !== exp) begin
            fails++;
            $display("FAIL reset_read_int: got %h, required %h", priv_rdata, exp);
        end
    endtask

    task automatic test_priv_write_irq();
        logic [63:0] exp;
        access(1'b0, 8'hFF, A_REQ, 64'hABCD_0000_0000_0032);
        access(1'b0, 8'hFF, A_INT, 64'h1);
        tests++;
        if (core_irq !== 1'b0) begin
            fails++;
            $display("FAIL irq_early: got %b, required 0 on the cycle after the INT write", core_irq);
        end
        @(posedge clk); #1;
        tests++;
        if (core_irq !== int_m[0]) begin
            fails++;
            $display("FAIL irq_set: got %b, required %b", core_irq, int_m[0]);
        end
        access(1'b1, 8'h00, A_REQ, 64'h0);
        exp = (q_core.size() != 0) ? q_core.pop_front() : 64'hx;
        tests++;
        if (core_rdata !== exp || exp !== 64'hABCD_0000_0000_0032) begin
            fails++;
            $display("FAIL core_read_req: got %h, required %h", core_rdata, 64'hABCD_0000_0000_0032);
        end
    endtask

    task automatic test_core_byte_write();
        logic [63:0] exp;
        access(1'b1, 8'h01, A_REQ, 64'hFFFF_FFFF_FFFF_FF01);
        access(1'b1, 8'hFF, A_INT, 64'h0);
        access(1'b0, 8'h00, A_REQ, 64'h0);
        exp = (q_priv.size() != 0) ? q_priv.pop_front() : 64'hx;
        tests++;
        if (priv_rdata !== exp || exp !== 64'hABCD_0000_0000_0001) begin
            fails++;
            $display("FAIL byte_write: got %h, required %h", priv_rdata, 64'hABCD_0000_0000_0001);
        end
        access(1'b0, 8'h00, A_INT, 64'h0);
        exp = (q_priv.size() != 0) ? q_priv.pop_front() : 64'hx;
        tests++;
        if (priv_rdata !== exp) begin
            fails++;
            $display("FAIL int_clear_read: got %h, required %h", priv_rdata, exp);
        end
        tests++;
        if (core_irq !== 1'b0) begin
            fails++;
            $display("FAIL irq_clear: got %b, required 0", core_irq);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        bit exp_pstall;
        bit exp_cstall;
        do_reset();
        access(1'b0, 8'hFF, A_REQ, 64'h1122_3344_5566_7788);
        access(1'b1, 8'hFF, A_INT, 64'h0000_0000_0000_5A00);
        priv_en = 1'b1; priv_wben = 8'h00; priv_addr = A_REQ;
        core_en = 1'b1; core_wben = 8'h00; core_addr = A_INT;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_pstall = (i % 2) == 1;
            exp_cstall = (i % 2) == 0;
            tests++;
            if (priv_stall !== exp_pstall || core_stall !== exp_cstall) begin
                fails++;
                $display("FAIL rr_stall[%0d]: pstall=%b cstall=%b, required %b %b",
                         i, priv_stall, core_stall, exp_pstall, exp_cstall);
            end
            model_accept(exp_cstall ? 1'b0 : 1'b1, 8'h00, exp_cstall ? A_REQ : A_INT, 64'h0);
            @(posedge clk); #1;
            if (exp_cstall) begin
                exp = (q_priv.size() != 0) ? q_priv.pop_front() : 64'hx;
                tests++;
                if (priv_rdata !== exp) begin
                    fails++;
                    $display("FAIL rr_priv_rdata[%0d]: got %h, required %h", i, priv_rdata, exp);
                end
            end else begin
                exp = (q_core.size() != 0) ? q_core.pop_front() : 64'hx;
                tests++;
                if (core_rdata !== exp) begin
                    fails++;
                    $display("FAIL rr_core_rdata[%0d]: got %h, required %h", i, core_rdata, exp);
                end
            end
        end
        priv_en = 1'b0;
        core_en = 1'b0;
    endtask

    task automatic test_unmapped();
        logic [63:0] exp;
        access(1'b0, 8'h00, A_UNMAP, 64'h0);
        exp = (q_priv.size() != 0) ? q_priv.pop_front() : 64'hx;
        tests++;
        if (priv_rdata !== exp || exp !== 64'h0) begin
            fails++;
            $display("FAIL unmapped_read: got %h, required 0", priv_rdata);
        end
        access(1'b0, 8'hFF, A_UNMAP, 64'hDEAD_BEEF_DEAD_BEEF);
        access(1'b1, 8'h00, A_REQ, 64'hCAFE_CAFE_CAFE_CAFE);
        exp = (q_core.size() != 0) ? q_core.pop_front() : 64'hx;
        tests++;
        if (core_rdata !== exp) begin
            fails++;
            $display("FAIL wben0_is_read: got %h, required %h", core_rdata, exp);
        end
        access(1'b0, 8'h00, A_REQ, 64'h0);
        exp = (q_priv.size() != 0) ? q_priv.pop_front() : 64'hx;
        tests++;
        if (priv_rdata !== exp || exp !== 64'h1122_3344_5566_7788) begin
            fails++;
            $display("FAIL req_unchanged: got %h, required %h", priv_rdata, 64'h1122_3344_5566_7788);
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] exp;
        access(1'b1, 8'hFF, A_INT, 64'h1);
        @(posedge clk); #1;
        access(1'b0, 8'h00, A_REQ, 64'h0);
        void'(q_priv.pop_front());
        tests++;
        if (core_irq !== 1'b1 || priv_rdata === 64'h0) begin
            fails++;
            $display("FAIL pre_reset_state: irq=%b prdata=%h, required 1 and nonzero", core_irq, priv_rdata);
        end
        priv_en = 1'b1; priv_wben = 8'h00; priv_addr = A_REQ;
        core_en = 1'b1; core_wben = 8'h00; core_addr = A_INT;
        #3 reset_n = 1'b0;
        #1;
        tests++;
        if (core_irq !== 1'b0 || priv_rdata !== 64'h0 || core_rdata !== 64'h0 ||
            priv_stall !== 1'b0 || core_stall !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: irq=%b prdata=%h crdata=%h pstall=%b cstall=%b, required all 0",
                     core_irq, priv_rdata, core_rdata, priv_stall, core_stall);
        end
        priv_en = 1'b0;
        core_en = 1'b0;
        @(posedge clk); #1;
        do_reset();
        access(1'b0, 8'h00, A_REQ, 64'h0);
        exp = (q_priv.size() != 0) ? q_priv.pop_front() : 64'hx;
        tests++;
        if (priv_rdata !== exp || exp !== 64'h0) begin
            fails++;
            $display("FAIL req_after_reset: got %h, required 0", priv_rdata);
        end
        access(1'b1, 8'h00, A_INT, 64'h0);
        exp = (q_core.size() != 0) ? q_core.pop_front() : 64'hx;
        tests++;
        if (core_rdata !== exp || exp !== 64'h0) begin
            fails++;
            $display("FAIL int_after_reset: got %h, required 0", core_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_priv_write_irq();
        test_core_byte_write();
        test_back_to_back();
        test_unmapped();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
